out_writeback: RTL and testbench

- Downstream neighbour of the convolution sequencer and the batch controller.
- Captures one accumulator result per cycle while outr is high, indexed by kernel number ra and output address oa.
- Adds a per-kernel bias, then quantizes with round-half-up and signed saturation, and writes the result into the output buffer.
- Serves the batch controller's drain reads (dst_v/dst_a) and drives dst_ready so the drain never overtakes in-flight writes.

---
 rtl/tiny_dnn_pkg.sv | 41 ++++
 rtl/out_writeback_quant.sv | 22 ++
 rtl/out_writeback.sv | 145 ++++++++++++++
 tb/tb_out_writeback.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_dnn_pkg.sv
// Shared sizes, types and the round/saturate helper used by the output writeback path.
package tiny_dnn_pkg;

  localparam int AW   = 13;
  localparam int DW   = 16;
  localparam int ACCW = 32;
  localparam int KN   = 16;
  localparam int KW   = 4;

  typedef logic signed [ACCW-1:0] acc_t;
  typedef logic signed [ACCW:0]   sum_t;
  typedef logic signed [DW-1:0]   res_t;
  typedef logic [AW-1:0]          oaddr_t;
  typedef logic [KW-1:0]          kidx_t;

  // One guard bit above the sum so the rounding increment can never wrap.
  localparam logic signed [ACCW+1:0] SAT_HI = $signed((ACCW+2)'((1 << (DW-1)) - 1));
  localparam logic signed [ACCW+1:0] SAT_LO = ~SAT_HI;

  function automatic res_t sat_round(input sum_t sum, input logic [4:0] qshift);
    logic signed [ACCW+1:0] t;
    logic signed [ACCW+1:0] half;
    res_t                   r;
    t    = {sum[ACCW], sum};
    half = '0;
    if (qshift != 5'd0) begin
      half = (ACCW+2)'(1) << (qshift - 5'd1);
      t    = t + half;
      t    = t >>> qshift;
    end
    if (t > SAT_HI) begin
      r = SAT_HI[DW-1:0];
    end else if (t < SAT_LO) begin
      r = SAT_LO[DW-1:0];
    end else begin
      r = t[DW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/out_writeback_quant.sv
// out_quant: combinational ReLU, round-half-up and signed saturation of a biased sum.
module out_quant
  import tiny_dnn_pkg::*;
(
  input  logic [ACCW:0] sum,
  input  logic [4:0]    qshift,
  input  logic          relu_en,
  output logic [DW-1:0] q
);

  sum_t relu_sum;

  always_comb begin
    relu_sum = sum_t'(sum);
    if (relu_en && sum[ACCW]) begin
      relu_sum = '0;
    end
  end

  assign q = sat_round(relu_sum, qshift);

endmodule

// File: rtl/out_writeback.sv
// out_writeback: bias add, quantize and write accumulator results into the output buffer, and serve drain reads.
// Optional runtime ReLU (relu_on port) is built when OUT_WRITEBACK_RELU_EN is defined.
module out_writeback
  import tiny_dnn_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            bwrite,
  input  logic            bias_valid,
  input  logic [DW-1:0]   bias_data,
  input  logic            outr,
  input  logic [KW-1:0]   ra,
  input  logic [AW-1:0]   oa,
  input  logic [ACCW-1:0] acc,
  input  logic [4:0]      qshift,
`ifdef OUT_WRITEBACK_RELU_EN
  input  logic            relu_on,
`endif
  input  logic            dst_v,
  input  logic [AW-1:0]   dst_a,
  output logic            dst_ready,
  output logic [DW-1:0]   dst_data,
  output logic            dst_data_valid,
  output logic [AW:0]     wr_cnt
);

  logic [DW-1:0] bias_reg [KN];
  kidx_t         bidx_reg;
  logic [KN-1:0] bias_we;

  logic          v1_reg, v2_reg, v3_reg;
  kidx_t         ra1_reg;
  oaddr_t        oa1_reg, oa2_reg;
  acc_t          acc1_reg;
  sum_t          sum2_reg;
  logic [DW-1:0] bias_sel;
  logic [DW-1:0] q3;
  logic          relu_en;

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_reg;
  logic          rd_seen_reg;
  logic          dst_valid_reg;
  logic [AW:0]   wr_cnt_reg;

`ifdef OUT_WRITEBACK_RELU_EN
  assign relu_en = relu_on;
`else
  assign relu_en = 1'b0;
`endif

  for (genvar gi = 0; gi < KN; gi++) begin : g_bias_we
    assign bias_we[gi] = bwrite & bias_valid & (bidx_reg == KW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KN; i++) bias_reg[i] <= '0;
    end else begin
      for (int i = 0; i < KN; i++) begin
        if (bias_we[i]) bias_reg[i] <= bias_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bidx_reg <= '0;
    end else if (!bwrite) begin
      bidx_reg <= '0;
    end else if (bias_valid) begin
      bidx_reg <= (bidx_reg == KW'(KN-1)) ? '0 : bidx_reg + 1'b1;
    end
  end

  // v3 marks the cycle right after the RAM write so a drain never races it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else begin
      v1_reg <= outr;
      v2_reg <= v1_reg;
      v3_reg <= v2_reg;
    end
  end

  // Bias is read from the registered table, so a same-cycle bias write only affects later results.
  assign bias_sel = bias_reg[ra1_reg];

  always_ff @(posedge clk) begin
    if (outr) begin
      ra1_reg  <= ra;
      oa1_reg  <= oa;
      acc1_reg <= acc;
    end
    oa2_reg  <= oa1_reg;
    sum2_reg <= sum_t'({acc1_reg[ACCW-1], acc1_reg})
              + sum_t'({{(ACCW+1-DW){bias_sel[DW-1]}}, bias_sel});
  end

  out_quant u_quant (
    .sum     (sum2_reg),
    .qshift  (qshift),
    .relu_en (relu_en),
    .q       (q3)
  );

  always_ff @(posedge clk) begin
    if (v2_reg) mem[oa2_reg] <= q3;
  end

  always_ff @(posedge clk) begin
    if (dst_v) rd_data_reg <= mem[dst_a];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_seen_reg   <= 1'b0;
      dst_valid_reg <= 1'b0;
    end else begin
      rd_seen_reg   <= rd_seen_reg | dst_v;
      dst_valid_reg <= dst_v;
    end
  end

  // Clearing waits for the pipeline to empty so late writes of a finished layer are still counted first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_reg <= '0;
    end else if (v2_reg) begin
      wr_cnt_reg <= wr_cnt_reg + 1'b1;
    end else if (!run && !v1_reg) begin
      wr_cnt_reg <= '0;
    end
  end

  assign dst_ready      = ~(v1_reg | v2_reg | v3_reg);
  assign dst_data       = rd_seen_reg ? rd_data_reg : '0;
  assign dst_data_valid = dst_valid_reg;
  assign wr_cnt         = wr_cnt_reg;

endmodule

// File: tb/tb_out_writeback.sv
// Self-checking bench for out_writeback: table vectors, randomized bursts against a reference model, and corner sequences.
module tb_out_writeback;
  import tiny_dnn_pkg::*;

`ifdef OUT_WRITEBACK_RELU_EN
  localparam bit RELU_BUILT = 1'b1;
`else
  localparam bit RELU_BUILT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            run = 1'b0;
  logic            bwrite = 1'b0;
  logic            bias_valid = 1'b0;
  logic [DW-1:0]   bias_data = '0;
  logic            outr = 1'b0;
  logic [KW-1:0]   ra = '0;
  logic [AW-1:0]   oa = '0;
  logic [ACCW-1:0] acc = '0;
  logic [4:0]      qshift = '0;
  logic            relu_on = 1'b0;
  logic            dst_v = 1'b0;
  logic [AW-1:0]   dst_a = '0;
  logic            dst_ready;
  logic [DW-1:0]   dst_data;
  logic            dst_data_valid;
  logic [AW:0]     wr_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic signed [DW-1:0] bias_m [KN];
  int                   bidx_m = 0;

  typedef struct {
    int          ra;
    int          oa;
    int          acc;
    int          sh;
    bit          relu;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t tv [NV];

  out_writeback dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .bwrite         (bwrite),
    .bias_valid     (bias_valid),
    .bias_data      (bias_data),
    .outr           (outr),
    .ra             (ra),
    .oa             (oa),
    .acc            (acc),
    .qshift         (qshift),
`ifdef OUT_WRITEBACK_RELU_EN
    .relu_on        (relu_on),
`endif
    .dst_v          (dst_v),
    .dst_a          (dst_a),
    .dst_ready      (dst_ready),
    .dst_data       (dst_data),
    .dst_data_valid (dst_data_valid),
    .wr_cnt         (wr_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && dst_v && !dst_ready) begin
      miscompares++;
      $display("FAIL dst_protocol: dst_v=1 while dst_ready=0 at %0t", $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Reference: biased sum, optional ReLU, floor((s + half) / 2^sh), clamp to 16-bit signed.
  function automatic logic [15:0] model_q(input longint a, input longint b, input int sh, input bit relu);
    longint s, d, q;
    s = a + b;
    if (relu && s < 0) s = 0;
    q = s;
    if (sh > 0) begin
      d = longint'(1) << sh;
      s = s + d / 2;
      q = s / d;
      if ((s % d) != 0 && s < 0) q = q - 1;
    end
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic bias_word(input int v);
    bias_data  = 16'(v);
    bias_valid = 1'b1;
    step();
    bias_m[bidx_m] = 16'(v);
    bidx_m = (bidx_m + 1) % KN;
  endtask

  task automatic read_chk(input int o, input logic [15:0] e, input string name);
    dst_a = 13'(o);
    dst_v = 1'b1;
    step();
    dst_v = 1'b0;
    chk({name, "_data"}, 32'(dst_data), 32'(e));
    chk({name, "_dvalid"}, 32'(dst_data_valid), 32'd1);
    step();
    chk({name, "_dvalid_drop"}, 32'(dst_data_valid), 32'd0);
  endtask

  task automatic do_one(input int r, input int o, input int a, input logic [15:0] e, input string name);
    ra   = 4'(r);
    oa   = 13'(o);
    acc  = 32'(a);
    outr = 1'b1;
    step();
    outr = 1'b0;
    chk({name, "_rdy_lo1"}, 32'(dst_ready), 32'd0);
    step();
    step();
    chk({name, "_rdy_lo3"}, 32'(dst_ready), 32'd0);
    step();
    chk({name, "_rdy_hi"}, 32'(dst_ready), 32'd1);
    read_chk(o, e, name);
  endtask

  initial begin
    logic [15:0] ex [16];
    int kr, a;

    for (int i = 0; i < KN; i++) bias_m[i] = '0;

    tv[0]  = '{0, 5,    296,           4,  1'b0, 16'h0013};
    tv[1]  = '{1, 6,    32'h0010_0000, 0,  1'b0, 16'h7FFF};
    tv[2]  = '{1, 7,    -40000,        0,  1'b0, 16'h8000};
    tv[3]  = '{1, 8,    -100,          0,  1'b0, 16'hFF9C};
    tv[4]  = '{1, 9,    -100,          0,  1'b1, RELU_BUILT ? 16'h0000 : 16'hFF9C};
    tv[5]  = '{0, 10,   -100,          0,  1'b0, 16'hFFA4};
    tv[6]  = '{1, 11,   24,            4,  1'b0, 16'h0002};
    tv[7]  = '{1, 12,   -24,           4,  1'b0, 16'hFFFF};
    tv[8]  = '{1, 13,   -25,           4,  1'b0, 16'hFFFE};
    tv[9]  = '{1, 14,   32'h7FFF_FFFF, 31, 1'b0, 16'h0001};
    tv[10] = '{1, 15,   -3,            1,  1'b0, 16'hFFFF};
    tv[11] = '{1, 16,   3,             1,  1'b0, 16'h0002};
    tv[12] = '{1, 17,   32767,         0,  1'b0, 16'h7FFF};
    tv[13] = '{1, 18,   32768,         0,  1'b0, 16'h7FFF};
    tv[14] = '{1, 19,   -32769,        0,  1'b0, 16'h8000};
    tv[15] = '{1, 8191, 524280,        4,  1'b0, 16'h7FFF};
    tv[16] = '{1, 0,    -32768,        0,  1'b0, 16'h8000};
    tv[17] = '{0, 1,    -8,            0,  1'b0, 16'h0000};
    tv[18] = '{1, 2,    -524297,       4,  1'b0, 16'h8000};
    tv[19] = '{1, 3,    32'h8000_0000, 0,  1'b0, 16'h8000};

    // Reset state
    repeat (3) step();
    chk("rst_dst_ready", 32'(dst_ready), 32'd1);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("rst_dst_data", 32'(dst_data), 32'd0);
    chk("rst_dst_data_valid", 32'(dst_data_valid), 32'd0);
    rst_n = 1'b1;
    run   = 1'b1;
    step();

    // bias[0] = 8, all others stay 0
    bwrite = 1'b1;
    bias_word(8);
    bwrite = 1'b0;
    bias_valid = 1'b0;
    bidx_m = 0;
    step();

    for (int i = 0; i < NV; i++) begin
      qshift  = 5'(tv[i].sh);
      relu_on = tv[i].relu;
      do_one(tv[i].ra, tv[i].oa, tv[i].acc, tv[i].exp, $sformatf("vec%0d", i));
    end
    chk("table_wr_cnt", 32'(wr_cnt), 32'(NV));
    qshift  = '0;
    relu_on = 1'b0;

    // Bias load with wrap: 17 words into 16 entries
    step();
    bwrite = 1'b1;
    for (int v = 1; v <= 17; v++) bias_word(v);
    bwrite = 1'b0;
    bias_valid = 1'b0;
    bidx_m = 0;
    step();
    do_one(0, 20, 0, 16'd17, "bias_wrap0");
    do_one(1, 21, 0, 16'd2, "bias_wrap1");

    // Write to bias[3] in the same cycle a ra=3 result sits in S2
    bwrite = 1'b1;
    bias_word(17);
    bias_word(2);
    ra = 4'd3; oa = 13'd22; acc = 32'd1000; outr = 1'b1;
    bias_word(3);
    outr = 1'b0;
    bias_word(999);
    bwrite = 1'b0;
    bias_valid = 1'b0;
    bidx_m = 0;
    step();
    step();
    chk("same_cyc_rdy_hi", 32'(dst_ready), 32'd1);
    read_chk(22, 16'd1004, "same_cyc_old_bias");
    do_one(3, 23, 1000, 16'd1999, "same_cyc_new_bias");

    // run low clears wr_cnt once idle
    run = 1'b0;
    step();
    chk("run_low_wr_cnt", 32'(wr_cnt), 32'd0);
    run = 1'b1;

    // Randomized back-to-back bursts and drains
    for (int r = 0; r < 3; r++) begin
      qshift  = 5'($urandom_range(0, 12));
      relu_on = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) begin
        kr = (r == 0) ? k : int'($urandom_range(0, 15));
        a  = int'($urandom);
        ra = 4'(kr); oa = 13'(k * 4 + r * 256); acc = 32'(a); outr = 1'b1;
        ex[k] = model_q(longint'(a), longint'(bias_m[kr]), int'(qshift), RELU_BUILT && relu_on);
        step();
        chk($sformatf("burst%0d_rdy_lo%0d", r, k), 32'(dst_ready), 32'd0);
      end
      outr = 1'b0;
      step();
      chk($sformatf("burst%0d_tail_lo2", r), 32'(dst_ready), 32'd0);
      step();
      chk($sformatf("burst%0d_tail_lo3", r), 32'(dst_ready), 32'd0);
      step();
      chk($sformatf("burst%0d_tail_hi", r), 32'(dst_ready), 32'd1);
      chk($sformatf("burst%0d_wr_cnt", r), 32'(wr_cnt), 32'(16 * (r + 1)));
      for (int k = 0; k < 16; k++) begin
        dst_a = 13'(k * 4 + r * 256);
        dst_v = 1'b1;
        step();
        chk($sformatf("drain%0d_data%0d", r, k), 32'(dst_data), 32'(ex[k]));
        chk($sformatf("drain%0d_dvalid%0d", r, k), 32'(dst_data_valid), 32'd1);
      end
      dst_v = 1'b0;
      step();
      chk($sformatf("drain%0d_dvalid_drop", r), 32'(dst_data_valid), 32'd0);
    end
    qshift  = '0;
    relu_on = 1'b0;

    // Simultaneous outr and dst_v
    ra = 4'd2; oa = 13'd200; acc = 32'd5; outr = 1'b1;
    dst_a = 13'd5; dst_v = 1'b1;
    step();
    outr = 1'b0;
    dst_v = 1'b0;
    chk("simul_data", 32'(dst_data), 32'h0013);
    chk("simul_dvalid", 32'(dst_data_valid), 32'd1);
    chk("simul_rdy_lo", 32'(dst_ready), 32'd0);
    step(); step(); step();
    chk("simul_rdy_hi", 32'(dst_ready), 32'd1);
    read_chk(200, model_q(64'sd5, longint'(bias_m[2]), 0, 1'b0), "simul_write");

    // run falls while two results are in flight
    ra = 4'd0; oa = 13'd300; acc = 32'd7; outr = 1'b1;
    step();
    oa = 13'd301; acc = 32'd9;
    step();
    outr = 1'b0;
    run  = 1'b0;
    step(); step(); step(); step();
    chk("runfall_wr_cnt", 32'(wr_cnt), 32'd0);
    run = 1'b1;
    read_chk(300, 16'd24, "runfall_a");
    read_chk(301, 16'd26, "runfall_b");

    // Reset two cycles into a burst
    do_one(0, 400, 1234, 16'd1251, "pre_rst");
    ra = 4'd0; oa = 13'd400; acc = -32'sd5; outr = 1'b1;
    dst_a = 13'd5; dst_v = 1'b1;
    step();
    dst_v = 1'b0;
    oa = 13'd401;
    step();
    rst_n = 1'b0;
    outr  = 1'b0;
    #1;
    chk("midrst_dst_ready", 32'(dst_ready), 32'd1);
    chk("midrst_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("midrst_dst_data_valid", 32'(dst_data_valid), 32'd0);
    chk("midrst_dst_data", 32'(dst_data), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < KN; i++) bias_m[i] = '0;
    bidx_m = 0;
    step();
    read_chk(400, 16'd1251, "midrst_no_write");
    do_one(0, 402, 50, 16'd50, "post_rst_bias_clear");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
